// File: rtl/spi_slave_pkg.sv
// Shared types and AXI constants for the SPI slave system-side AXI master.
// FSM encoding plus fixed AXI field values.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RD_PUSH
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32    = 3'b010;

endpackage

// File: rtl/spi_slave_axi_master.sv
// Turns SPI address tokens and write words into single-beat AXI4 accesses;
// read words are prefetched one at a time into the TX FIFO.
module spi_slave_axi_master
  import spi_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic [31:0]                 rx_addr,
  input  logic                        rx_rd_wr,
  input  logic                        rx_addr_valid,
  output logic                        rx_addr_ready,
  input  logic [31:0]                 rx_wdata,
  input  logic                        rx_wdata_valid,
  output logic                        rx_wdata_ready,
  output logic [31:0]                 tx_rdata,
  output logic                        tx_rdata_valid,
  input  logic                        tx_rdata_ready,
  input  logic [15:0]                 wrap_length,
  output logic                        resp_err,
  output logic [AXI_ID_WIDTH-1:0]     axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]                  axi_awlen,
  output logic [2:0]                  axi_awsize,
  output logic [1:0]                  axi_awburst,
  output logic [2:0]                  axi_awprot,
  output logic [3:0]                  axi_awcache,
  output logic                        axi_awlock,
  output logic [3:0]                  axi_awqos,
  output logic [3:0]                  axi_awregion,
  output logic [AXI_USER_WIDTH-1:0]   axi_awuser,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic [AXI_USER_WIDTH-1:0]   axi_wuser,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]                  axi_bresp,
  input  logic [AXI_USER_WIDTH-1:0]   axi_buser,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [AXI_ID_WIDTH-1:0]     axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic [2:0]                  axi_arsize,
  output logic [1:0]                  axi_arburst,
  output logic [2:0]                  axi_arprot,
  output logic [3:0]                  axi_arcache,
  output logic                        axi_arlock,
  output logic [3:0]                  axi_arqos,
  output logic [3:0]                  axi_arregion,
  output logic [AXI_USER_WIDTH-1:0]   axi_aruser,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rlast,
  input  logic [AXI_USER_WIDTH-1:0]   axi_ruser,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int OW = AXI_ADDR_WIDTH - 2;

  state_t        state, nxt;
  logic [AW-1:0] base, addr, addr_adv;
  logic [OW-1:0] off, off_nxt;
  logic [31:0]   wword, rword;
  logic          live, aw_done, w_done;
  logic          load, adv, cap, latch_w, err_set;
  logic          unused_in;

  assign unused_in = ^{axi_bid, axi_buser, axi_rid, axi_rlast, axi_ruser};

  assign axi_awid     = '0;
  assign axi_awaddr   = addr;
  assign axi_awlen    = 8'd0;
  assign axi_awsize   = AXI_SIZE_32;
  assign axi_awburst  = AXI_BURST_INCR;
  assign axi_awprot   = 3'd0;
  assign axi_awcache  = 4'd0;
  assign axi_awlock   = 1'b0;
  assign axi_awqos    = 4'd0;
  assign axi_awregion = 4'd0;
  assign axi_awuser   = '0;
  assign axi_wlast    = 1'b1;
  assign axi_wuser    = '0;
  assign axi_arid     = '0;
  assign axi_araddr   = addr;
  assign axi_arlen    = 8'd0;
  assign axi_arsize   = AXI_SIZE_32;
  assign axi_arburst  = AXI_BURST_INCR;
  assign axi_arprot   = 3'd0;
  assign axi_arcache  = 4'd0;
  assign axi_arlock   = 1'b0;
  assign axi_arqos    = 4'd0;
  assign axi_arregion = 4'd0;
  assign axi_aruser   = '0;

  // 32-bit words ride in the lane picked by address bit 2
  if (AXI_DATA_WIDTH == 64) begin : g_dw64
    assign axi_wdata = {2{wword}};
    assign axi_wstrb = addr[2] ? 8'hF0 : 8'h0F;
    assign rword     = addr[2] ? axi_rdata[63:32] : axi_rdata[31:0];
  end else if (AXI_DATA_WIDTH == 32) begin : g_dw32
    assign axi_wdata = wword;
    assign axi_wstrb = 4'hF;
    assign rword     = axi_rdata;
  end else begin : g_bad
    $error("AXI_DATA_WIDTH must be 32 or 64");
  end

  always_comb begin
    off_nxt = off + 1'b1;
    if (wrap_length != 16'd0 && off_nxt == OW'(wrap_length))
      off_nxt = '0;
    addr_adv = base + {off_nxt, 2'b00};
  end

  always_comb begin
    nxt            = state;
    load           = 1'b0;
    adv            = 1'b0;
    cap            = 1'b0;
    latch_w        = 1'b0;
    err_set        = 1'b0;
    rx_addr_ready  = 1'b0;
    rx_wdata_ready = 1'b0;
    axi_awvalid    = 1'b0;
    axi_wvalid     = 1'b0;
    axi_bready     = 1'b0;
    axi_arvalid    = 1'b0;
    axi_rready     = 1'b0;
    unique case (state)
      IDLE: begin
        rx_addr_ready = live;
        if (live && rx_addr_valid) begin
          load = 1'b1;
          nxt  = rx_rd_wr ? RD_AR : WR_DATA;
        end
      end
      WR_DATA: begin
        rx_wdata_ready = 1'b1;
        rx_addr_ready  = !rx_wdata_valid;
        if (rx_wdata_valid) begin
          latch_w = 1'b1;
          nxt     = WR_AW_W;
        end else if (rx_addr_valid) begin
          load = 1'b1;
          nxt  = rx_rd_wr ? RD_AR : WR_DATA;
        end
      end
      WR_AW_W: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if ((aw_done || axi_awready) && (w_done || axi_wready))
          nxt = WR_B;
      end
      WR_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          adv     = 1'b1;
          err_set = axi_bresp != AXI_RESP_OKAY;
          nxt     = WR_DATA;
        end
      end
      RD_AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) nxt = RD_R;
      end
      RD_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          cap     = 1'b1;
          adv     = 1'b1;
          err_set = axi_rresp != AXI_RESP_OKAY;
          nxt     = RD_PUSH;
        end
      end
      RD_PUSH: begin
        rx_addr_ready = tx_rdata_ready;
        if (tx_rdata_ready) begin
          if (rx_addr_valid) begin
            load = 1'b1;
            nxt  = rx_rd_wr ? RD_AR : WR_DATA;
          end else begin
            nxt = RD_AR;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state          <= IDLE;
      live           <= 1'b0;
      base           <= '0;
      addr           <= '0;
      off            <= '0;
      wword          <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      tx_rdata       <= '0;
      tx_rdata_valid <= 1'b0;
      resp_err       <= 1'b0;
    end else begin
      state    <= nxt;
      live     <= 1'b1;
      resp_err <= err_set;
      if (load) begin
        base <= AW'(rx_addr);
        addr <= AW'(rx_addr);
        off  <= '0;
      end else if (adv) begin
        addr <= addr_adv;
        off  <= off_nxt;
      end
      if (latch_w) wword <= rx_wdata;
      if (state == WR_AW_W && nxt == WR_B) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (axi_awvalid && axi_awready) aw_done <= 1'b1;
        if (axi_wvalid && axi_wready) w_done <= 1'b1;
      end
      if (cap) begin
        tx_rdata       <= rword;
        tx_rdata_valid <= 1'b1;
      end else if (state == RD_PUSH && tx_rdata_ready) begin
        tx_rdata_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_axi_master.sv
// Directed bench: behavioural AXI slave with skew/latency knobs,
// handshake logs checked against hand-computed addresses and data.
module tb_spi_slave_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rx_addr = '0;
  logic        rx_rd_wr = 1'b0;
  logic        rx_addr_valid = 1'b0;
  logic        rx_addr_ready;
  logic [31:0] rx_wdata = '0;
  logic        rx_wdata_valid = 1'b0;
  logic        rx_wdata_ready;
  logic [31:0] tx_rdata;
  logic        tx_rdata_valid;
  logic        tx_rdata_ready = 1'b0;
  logic [15:0] wrap_length = '0;
  logic        resp_err;

  logic [5:0]  awid, arid, awuser, wuser, aruser;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion;
  logic        awlock, arlock, awvalid, wvalid, wlast, bready;
  logic        arvalid, rready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [63:0] rdata = '0;

  int n_chk = 0;
  int n_err = 0;
  int aw_lat = 0, r_lat = 0, aw_cnt = 0, r_cnt = 0;
  int b_cnt = 0, err_cnt = 0;
  logic [31:0] last_ar = '0;
  logic [31:0] aw_q[$], ar_q[$], pop_q[$];
  logic [7:0]  ws_q[$];
  logic [63:0] wd_q[$];

  localparam logic [31:0] ERR_ADDR = 32'hFFFF_FFFC;

  spi_slave_axi_master dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .rx_addr(rx_addr), .rx_rd_wr(rx_rd_wr),
    .rx_addr_valid(rx_addr_valid), .rx_addr_ready(rx_addr_ready),
    .rx_wdata(rx_wdata), .rx_wdata_valid(rx_wdata_valid),
    .rx_wdata_ready(rx_wdata_ready),
    .tx_rdata(tx_rdata), .tx_rdata_valid(tx_rdata_valid),
    .tx_rdata_ready(tx_rdata_ready),
    .wrap_length(wrap_length), .resp_err(resp_err),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awsize(awsize), .axi_awburst(awburst), .axi_awprot(awprot),
    .axi_awcache(awcache), .axi_awlock(awlock), .axi_awqos(awqos),
    .axi_awregion(awregion), .axi_awuser(awuser),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
    .axi_wuser(wuser), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(6'd0), .axi_bresp(bresp), .axi_buser(6'd0),
    .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
    .axi_arsize(arsize), .axi_arburst(arburst), .axi_arprot(arprot),
    .axi_arcache(arcache), .axi_arlock(arlock), .axi_arqos(arqos),
    .axi_arregion(arregion), .axi_aruser(aruser),
    .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(6'd0), .axi_rdata(rdata), .axi_rresp(rresp),
    .axi_rlast(1'b1), .axi_ruser(6'd0),
    .axi_rvalid(rvalid), .axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // AXI slave: responds one step after each posedge
  initial forever begin
    @(posedge clk);
    #1;
    if (awvalid) begin
      awready = aw_cnt >= aw_lat;
      aw_cnt++;
    end else begin
      awready = 1'b0;
      aw_cnt  = 0;
    end
    wready  = wvalid;
    bvalid  = bready;
    arready = arvalid;
    rdata   = {last_ar ^ 32'hFFFF_0000, last_ar};
    rresp   = (last_ar == ERR_ADDR) ? 2'b10 : 2'b00;
    if (rready) begin
      rvalid = r_cnt >= r_lat;
      r_cnt++;
    end else begin
      rvalid = 1'b0;
      r_cnt  = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (awvalid && awready) aw_q.push_back(awaddr);
    if (wvalid && wready) begin
      ws_q.push_back(wstrb);
      wd_q.push_back(wdata);
    end
    if (bvalid && bready) b_cnt++;
    if (arvalid && arready) begin
      ar_q.push_back(araddr);
      last_ar = araddr;
    end
    if (tx_rdata_valid && tx_rdata_ready) pop_q.push_back(tx_rdata);
    if (resp_err) err_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [31:0] a, input logic rd);
    int n = 0;
    rx_addr = a;
    rx_rd_wr = rd;
    rx_addr_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_addr_ready && n < 200);
    check("addr_hs", n < 200, 1);
    step(1);
    rx_addr_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    rx_wdata = w;
    rx_wdata_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_wdata_ready && n < 200);
    check("word_hs", n < 200, 1);
    step(1);
    rx_wdata_valid = 1'b0;
  endtask

  task automatic wait_pops(input int k);
    int n = 0;
    while (pop_q.size() < k && n < 200) begin
      step(1);
      n++;
    end
    check("pop_to", n < 200, 1);
  endtask

  initial begin
    int n;
    step(5);
    @(negedge clk);
    check("rst_valid", {awvalid, wvalid, arvalid, bready, rready,
                        tx_rdata_valid, resp_err}, 0);
    check("rst_ready", {rx_addr_ready, rx_wdata_ready}, 0);
    check("rst_txd", tx_rdata, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("idle_rdy", rx_addr_ready, 1);
    check("idle_quiet", aw_q.size() + ar_q.size(), 0);

    aw_lat = 3;
    send_addr(32'h1000, 1'b0);
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    send_word(32'hCCCC_0003);
    n = 0;
    while (b_cnt < 3 && n < 200) begin step(1); n++; end
    check("wr_b_cnt", b_cnt, 3);
    check("wr_aw0", aw_q[0], 32'h1000);
    check("wr_aw1", aw_q[1], 32'h1004);
    check("wr_aw2", aw_q[2], 32'h1008);
    check("wr_st0", ws_q[0], 8'h0F);
    check("wr_st1", ws_q[1], 8'hF0);
    check("wr_st2", ws_q[2], 8'h0F);
    check("wr_wd1", wd_q[1], 64'hBBBB_0002_BBBB_0002);
    aw_lat = 0;

    send_addr(32'h2004, 1'b1);
    step(12);
    check("pf_ar_cnt", ar_q.size(), 1);
    check("pf_ar0", ar_q[0], 32'h2004);
    check("pf_txv", tx_rdata_valid, 1);
    check("pf_txd", tx_rdata, 32'hFFFF_2004);
    tx_rdata_ready = 1'b1;
    wait_pops(1);
    tx_rdata_ready = 1'b0;
    step(8);
    check("pf_ar_cnt2", ar_q.size(), 2);
    check("pf_ar1", ar_q[1], 32'h2008);
    check("pf_pop0", pop_q[0], 32'hFFFF_2004);
    check("pf_txd2", tx_rdata, 32'h0000_2008);

    wrap_length = 16'd4;
    tx_rdata_ready = 1'b1;
    send_addr(32'h3008, 1'b1);
    wait_pops(8);
    tx_rdata_ready = 1'b0;
    step(8);
    check("wr_ar2", ar_q[2], 32'h3008);
    check("wr_ar3", ar_q[3], 32'h300C);
    check("wr_ar4", ar_q[4], 32'h3010);
    check("wr_ar5", ar_q[5], 32'h3014);
    check("wr_ar6", ar_q[6], 32'h3008);
    check("wr_ar7", ar_q[7], 32'h300C);
    check("wrap_pop3", pop_q[3], 32'hFFFF_300C);
    check("wrap_pop6", pop_q[6], 32'h0000_3008);

    wrap_length = 16'd0;
    tx_rdata_ready = 1'b1;
    send_addr(ERR_ADDR, 1'b1);
    wait_pops(10);
    tx_rdata_ready = 1'b0;
    step(8);
    check("err_ar9", ar_q[9], ERR_ADDR);
    check("err_ar10", ar_q[10], 32'h0);
    check("err_pop9", pop_q[9], 32'h0000_FFFC);
    check("err_pulses", err_cnt, 1);

    r_lat = 4;
    tx_rdata_ready = 1'b1;
    wait_pops(11);
    tx_rdata_ready = 1'b0;
    n = 0;
    while (ar_q.size() < 12 && n < 200) begin step(1); n++; end
    check("mr_ar11", ar_q[11], 32'h4);
    rx_addr = 32'h4000;
    rx_rd_wr = 1'b0;
    rx_addr_valid = 1'b1;
    @(negedge clk);
    check("mr_no_acc", {rx_addr_ready, rready}, 2'b01);
    n = 0;
    while (!tx_rdata_valid && n < 200) begin step(1); n++; end
    check("mr_txd", tx_rdata, 32'hFFFF_0004);
    tx_rdata_ready = 1'b1;
    step(1);
    tx_rdata_ready = 1'b0;
    rx_addr_valid = 1'b0;
    check("mr_pop", pop_q.size(), 12);
    check("mr_pop11", pop_q[11], 32'hFFFF_0004);
    step(10);
    check("mr_no_ar", ar_q.size(), 12);
    check("mr_wrdy", rx_wdata_ready, 1);
    send_word(32'hDDDD_0004);
    n = 0;
    while (b_cnt < 4 && n < 200) begin step(1); n++; end
    check("mr_b_cnt", b_cnt, 4);
    check("mr_aw3", aw_q[3], 32'h4000);
    check("mr_st3", ws_q[3], 8'h0F);
    check("mr_wd3", wd_q[3], 64'hDDDD_0004_DDDD_0004);
    check("end_err", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
